operand_streamer: RTL and testbench
===================================

# operand_streamer

Drives the operand, scale and position streams of the stage-sequenced fp16 pipe stage from a preloaded operand buffer and writes its per-step results back to a result buffer. It owns the pipe's stage-boundary table and step alignment: it holds the pipe in reset while idle, releases it in lockstep with its own step counter, and stops when the pipe reports stage 7. It sits between the operand/result SRAMs and the pipe stage in each attention-sparsity lane group.

## Interface
- PARA, 8: step/address width; buffer depth is 2^PARA.
- WIDTH, 16: fp16 lane width.
- PARALLEL_SIZE, 2: lanes per step.
- CAPTURE_MASK, 8'b0111_0000: bit s set means results produced in stage s are written back.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run (sampled in IDLE only).
- boundary_cfg  in  [6:0][PARA-1:0]  requested stage boundaries.
- busy  out  1  high in PRIME/RUN.
- done  out  1  one-cycle pulse at run end.
- ovf  out  1  valid with done; run ended on step wrap rather than stage 7.
- cfg_err  out  1  one-cycle pulse; start rejected.
- stage_boundary  out  [6:0][PARA-1:0]  latched table to pipe.
- pipe_rst  out  1  reset to pipe stage.
- stage_i  in  3  pipe stage.
- finished_i  in  1  pipe finished.
- rd_en / rd_addr  out  1 / PARA  operand buffer read, 1-cycle latency.
- rd_data  in  [PARALLEL_SIZE][3][WIDTH]  {pos, scale, operand} per lane.
- operand_o, scale_o, pos_o  out  [PARALLEL_SIZE][WIDTH]  to pipe.
- res1_i, res2_i  in  [PARALLEL_SIZE][WIDTH]  pipe operand1/operand2.
- wr_en / wr_addr / wr_data  out  1 / PARA / [PARALLEL_SIZE][2][WIDTH]  result buffer write.

## Operation
- States IDLE, PRIME, RUN, DONE.
- IDLE: pipe_rst=1, streams 0. On start: if boundary_cfg non-decreasing ([i] <= [i+1] for all i), latch it into stage_boundary and go PRIME; otherwise pulse cfg_err and stay IDLE.
- PRIME (1 cycle): pipe_rst=1, rd_en=1, rd_addr=0, k=0.
- RUN: pipe_rst=0; k is the step counter, equal to the pipe step each cycle.
  - operand_o/scale_o/pos_o = rd_data (combinational pass-through); zero outside RUN.
  - rd_en=1, rd_addr=k+1 while k+1 <= B6+1 and k+1 < 2^PARA; otherwise rd_en=0.
  - wr_en = CAPTURE_MASK[stage_i]; wr_addr=k; wr_data = {res2_i, res1_i}.
- Exit from RUN to DONE:
  - when finished_i=1 (k = B6+1); that cycle is not written (mask bit 7 = 0);
  - or when k = 2^PARA-1 with finished_i=0, after writing step k; in this case ovf=1.
- DONE (1 cycle): done=1, pipe_rst=1, then IDLE.
- start outside IDLE is ignored; boundary_cfg changes after latch have no effect.
- Equal boundaries are legal; they give zero-length stages.

## Timing
- start in cycle S goes to PRIME in S+1. RUN runs for k=0 in S+2 through k=B6+1 in S+B6+3. done pulses in S+B6+4.
- Read address is issued one cycle ahead; data is consumed in the same cycle the pipe step equals the address.
- rst takes effect at the next edge from any state. After it: IDLE, pipe_rst=1, and busy, done, ovf, cfg_err, rd_en, wr_en, rd_addr, wr_addr, streams and stage_boundary all 0.

## Configuration
- OPERAND_STREAMER_WB_EN defined: result write-back port is active as described above.
- Undefined: capture logic is removed; wr_en, wr_addr and wr_data are tied to 0. Streaming and termination are unchanged.

## Structure
- Shared package holds:
  - stream-state enum;
  - stage code constants 0..7;
  - lane bundle struct {pos, scale, operand};
  - result struct {res2, res1}.
- One sub-module, operand_streamer_cfg_chk, combinationally checks that the boundary table is monotonic.

## Test plan
- Boundaries {2,4,6,8,10,12,14}, start at S -> rd_addr 0..15, operand_o at S+2+k equals buffer[k], wr_en exactly at k=9..14 (6 writes), done at S+18, ovf=0.
- Boundaries {2,4,3,8,10,12,14} -> cfg_err pulse, no rd_en, busy stays 0.
- start pulsed at S+5 during the run above -> no effect; done still at S+18.
- B6=255 -> run to k=255 with final write at addr 255, done with ovf=1, no read above address 255.
- rst at k=6 -> next cycle IDLE, pipe_rst=1, all outputs 0; a later start runs cleanly from k=0.
- OPERAND_STREAMER_WB_EN undefined, first scenario -> wr_en never 1, done at S+18.

Source files
------------

// File: rtl/operand_streamer_pkg.sv
// -----------------------------------------------------------------------------
// operand_streamer_pkg
// Shared types and constants for the operand streamer slice:
//   - stream_state_t : sequencing states of the streamer
//   - STAGE_0..7     : pipe stage codes reported on stage_i
//   - lane_bundle_t  : one lane of an operand-buffer word {pos, scale, operand}
//   - result_t       : one lane of a result-buffer word {res2, res1}
// -----------------------------------------------------------------------------
package operand_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_t;

    localparam logic [2:0] STAGE_0 = 3'd0;
    localparam logic [2:0] STAGE_1 = 3'd1;
    localparam logic [2:0] STAGE_2 = 3'd2;
    localparam logic [2:0] STAGE_3 = 3'd3;
    localparam logic [2:0] STAGE_4 = 3'd4;
    localparam logic [2:0] STAGE_5 = 3'd5;
    localparam logic [2:0] STAGE_6 = 3'd6;
    localparam logic [2:0] STAGE_7 = 3'd7;

    // Lane element width of the fp16 pipe.
    localparam int FP_WIDTH = 16;

    // Field order matches the buffer word layout: pos is the most significant.
    typedef struct packed {
        logic [FP_WIDTH-1:0] pos;
        logic [FP_WIDTH-1:0] scale;
        logic [FP_WIDTH-1:0] operand;
    } lane_bundle_t;

    typedef struct packed {
        logic [FP_WIDTH-1:0] res2;
        logic [FP_WIDTH-1:0] res1;
    } result_t;

endpackage

// File: rtl/operand_streamer_if.sv
// -----------------------------------------------------------------------------
// operand_streamer_if
// Bundles the pipe-stage and buffer-side signals of the operand streamer.
//   master : streamer side (drives pipe streams, boundary table, buffer ports)
//   slave  : pipe stage + operand/result buffers
// Signals: stage_boundary, pipe_rst, stage_i, finished_i, rd_en, rd_addr,
//          rd_data, operand_o, scale_o, pos_o, res1_i, res2_i, wr_en,
//          wr_addr, wr_data.
// -----------------------------------------------------------------------------
interface operand_streamer_if #(
    parameter int PARA          = 8,
    parameter int WIDTH         = 16,
    parameter int PARALLEL_SIZE = 2
);
    logic [6:0][PARA-1:0]                    stage_boundary;
    logic                                    pipe_rst;
    logic [2:0]                              stage_i;
    logic                                    finished_i;
    logic                                    rd_en;
    logic [PARA-1:0]                         rd_addr;
    logic [PARALLEL_SIZE-1:0][2:0][WIDTH-1:0] rd_data;
    logic [PARALLEL_SIZE-1:0][WIDTH-1:0]     operand_o;
    logic [PARALLEL_SIZE-1:0][WIDTH-1:0]     scale_o;
    logic [PARALLEL_SIZE-1:0][WIDTH-1:0]     pos_o;
    logic [PARALLEL_SIZE-1:0][WIDTH-1:0]     res1_i;
    logic [PARALLEL_SIZE-1:0][WIDTH-1:0]     res2_i;
    logic                                    wr_en;
    logic [PARA-1:0]                         wr_addr;
    logic [PARALLEL_SIZE-1:0][1:0][WIDTH-1:0] wr_data;

    modport master (
        output stage_boundary, pipe_rst, rd_en, rd_addr,
               operand_o, scale_o, pos_o, wr_en, wr_addr, wr_data,
        input  stage_i, finished_i, rd_data, res1_i, res2_i
    );

    modport slave (
        input  stage_boundary, pipe_rst, rd_en, rd_addr,
               operand_o, scale_o, pos_o, wr_en, wr_addr, wr_data,
        output stage_i, finished_i, rd_data, res1_i, res2_i
    );
endinterface

// File: rtl/operand_streamer_cfg_chk.sv
// -----------------------------------------------------------------------------
// operand_streamer_cfg_chk
// Combinational check that a stage-boundary table is non-decreasing.
//   i_boundary_cfg : [6:0][PARA-1:0] requested boundaries
//   o_cfg_ok       : 1 when [i] <= [i+1] for every i (equal entries allowed)
// -----------------------------------------------------------------------------
module operand_streamer_cfg_chk
    import operand_streamer_pkg::*;
#(
    parameter int PARA = 8
) (
    input  logic [6:0][PARA-1:0] i_boundary_cfg,
    output logic                 o_cfg_ok
);

    // Any descending neighbour pair makes the table unusable.
    always_comb begin
        o_cfg_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i_boundary_cfg[i] > i_boundary_cfg[i+1]) begin
                o_cfg_ok = 1'b0;
            end else begin
                o_cfg_ok = o_cfg_ok;
            end
        end
    end

endmodule

// File: rtl/operand_streamer.sv
// -----------------------------------------------------------------------------
// operand_streamer
// Streams operand/scale/position lanes from a preloaded operand buffer into
// the stage-sequenced fp16 pipe, keeps the pipe in reset while idle, releases
// it in lockstep with its own step counter k and writes captured per-step
// results back to the result buffer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a run (only honoured in IDLE)
//   boundary_cfg  : requested stage-boundary table, latched on start
//   busy          : high in PRIME/RUN
//   done          : one-cycle pulse at run end
//   ovf           : with done; run ended on step wrap instead of stage 7
//   cfg_err       : one-cycle pulse, start rejected (non-monotonic table)
//   bus           : operand_streamer_if.master (pipe + buffer side)
// Optional build macro OPERAND_STREAMER_WB_EN: enables result write-back;
// when undefined wr_en/wr_addr/wr_data are tied to zero.
// -----------------------------------------------------------------------------
module operand_streamer
    import operand_streamer_pkg::*;
#(
    parameter int         PARA          = 8,
    parameter int         WIDTH         = 16,
    parameter int         PARALLEL_SIZE = 2,
    parameter logic [7:0] CAPTURE_MASK  = 8'b0111_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [6:0][PARA-1:0] boundary_cfg,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 cfg_err,
    operand_streamer_if.master   bus
);

    localparam logic [PARA:0]   STEP_ONE = {{PARA{1'b0}}, 1'b1};
    localparam logic [PARA-1:0] STEP_MAX = {PARA{1'b1}};

    stream_state_t        r_state;
    stream_state_t        w_next_state;
    logic [PARA-1:0]      r_k;
    logic [6:0][PARA-1:0] r_boundary;
    logic                 r_cfg_err;
    logic                 r_ovf;
    logic                 w_cfg_ok;
    logic                 w_accept;
    logic                 w_last_step;
    logic [PARA:0]        w_k_next;
    logic [PARA:0]        w_rd_limit;

    lane_bundle_t [PARALLEL_SIZE-1:0] w_lanes;

    operand_streamer_cfg_chk #(.PARA(PARA)) u_cfg_chk (
        .i_boundary_cfg (boundary_cfg),
        .o_cfg_ok       (w_cfg_ok)
    );

    // One bit wider than k so the k+1 comparisons cannot wrap at 2^PARA-1.
    assign w_k_next    = {1'b0, r_k} + STEP_ONE;
    assign w_rd_limit  = {1'b0, r_boundary[6]} + STEP_ONE;
    assign w_last_step = (r_k == STEP_MAX);
    assign w_accept    = (r_state == ST_IDLE) && start && w_cfg_ok;
    assign w_lanes     = bus.rd_data;

    assign cfg_err            = r_cfg_err;
    assign ovf                = r_ovf;
    assign bus.stage_boundary = r_boundary;

    // State register, step counter, boundary latch and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_k        <= {PARA{1'b0}};
            r_boundary <= '0;
            r_cfg_err  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cfg_err <= (r_state == ST_IDLE) && start && !w_cfg_ok;
            // ovf is only ever high in the DONE cycle that follows a wrap exit.
            r_ovf     <= (r_state == ST_RUN) && !bus.finished_i && w_last_step;
            if (w_accept) begin
                r_boundary <= boundary_cfg;
            end else begin
                r_boundary <= r_boundary;
            end
            if (r_state == ST_RUN) begin
                r_k <= w_k_next[PARA-1:0];
            end else begin
                r_k <= {PARA{1'b0}};
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_PRIME;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PRIME: w_next_state = ST_RUN;
            ST_RUN: begin
                if (bus.finished_i || w_last_step) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Control, read-port and operand-stream outputs.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        bus.pipe_rst  = 1'b1;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = {PARA{1'b0}};
        bus.operand_o = '0;
        bus.scale_o   = '0;
        bus.pos_o     = '0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_PRIME: begin
                busy      = 1'b1;
                bus.rd_en = 1'b1;
            end
            ST_RUN: begin
                busy         = 1'b1;
                bus.pipe_rst = 1'b0;
                // Prefetch the next step while it is still inside the table
                // and inside the buffer.
                if ((w_k_next <= w_rd_limit) && !w_k_next[PARA]) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = w_k_next[PARA-1:0];
                end else begin
                    bus.rd_en   = 1'b0;
                    bus.rd_addr = {PARA{1'b0}};
                end
                for (int l = 0; l < PARALLEL_SIZE; l++) begin
                    bus.operand_o[l] = w_lanes[l].operand;
                    bus.scale_o[l]   = w_lanes[l].scale;
                    bus.pos_o[l]     = w_lanes[l].pos;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef OPERAND_STREAMER_WB_EN
    result_t [PARALLEL_SIZE-1:0] w_res;

    // Result capture: write step k whenever the reporting stage is selected.
    always_comb begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = {PARA{1'b0}};
        w_res       = '0;
        if (r_state == ST_RUN) begin
            bus.wr_en   = CAPTURE_MASK[bus.stage_i];
            bus.wr_addr = r_k;
            for (int l = 0; l < PARALLEL_SIZE; l++) begin
                w_res[l].res2 = bus.res2_i[l];
                w_res[l].res1 = bus.res1_i[l];
            end
        end else begin
            bus.wr_en = 1'b0;
        end
    end

    assign bus.wr_data = w_res;
`else
    logic w_unused_wb;

    assign w_unused_wb = ^{bus.stage_i, bus.res1_i, bus.res2_i, CAPTURE_MASK};
    assign bus.wr_en   = 1'b0;
    assign bus.wr_addr = {PARA{1'b0}};
    assign bus.wr_data = '0;
`endif

endmodule

// File: tb/tb_operand_streamer.sv
`timescale 1ns/1ps
module tb_operand_streamer;
    import operand_streamer_pkg::*;

    localparam int PARA  = 8;
    localparam int WIDTH = 16;
    localparam int PS    = 2;
    localparam logic [7:0] MASK = 8'b0111_0000;
`ifdef OPERAND_STREAMER_WB_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    typedef logic [6:0][PARA-1:0] bnd_t;
    typedef struct {
        bnd_t bnd;
        int   inj_start;   // cycle offset of a stray start pulse, 0 = none
        bit   chg_cfg;     // change boundary_cfg after latch
        int   exp_err_c;   // cycle of cfg_err pulse, 0 = none
        int   exp_done;    // cycle of done pulse, 0 = none
        int   exp_wr;      // write count with write-back enabled
        int   exp_ovf;
        int   exp_rd;
        int   exp_max_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    bnd_t boundary_cfg;
    logic busy, done, ovf, cfg_err;

    operand_streamer_if #(.PARA(PARA), .WIDTH(WIDTH), .PARALLEL_SIZE(PS)) bus ();

    operand_streamer #(.PARA(PARA), .WIDTH(WIDTH), .PARALLEL_SIZE(PS), .CAPTURE_MASK(MASK)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .boundary_cfg (boundary_cfg),
        .busy         (busy),
        .done         (done),
        .ovf          (ovf),
        .cfg_err      (cfg_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- pipe / buffer models ----------------
    int   step = 0;
    bnd_t cur_bnd = '0;

    function automatic int stage_of(int s, bnd_t b);
        int n = 0;
        for (int i = 0; i < 7; i++) if (int'(b[i]) < s) n++;
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] pat(int a, int l, int f);
        return {2'(f), 2'(l), 4'h5, 8'(a)};
    endfunction

    function automatic logic [WIDTH-1:0] rpat(int s, int l, int r);
        return {2'(r), 2'(l), 4'hC, 8'(s)};
    endfunction

    always @(posedge clk) begin
        if (bus.pipe_rst) step <= 0;
        else              step <= step + 1;
    end

    assign bus.stage_i    = 3'(stage_of(step, cur_bnd));
    assign bus.finished_i = (stage_of(step, cur_bnd) == 7);

    always_comb begin
        for (int l = 0; l < PS; l++) begin
            bus.res1_i[l] = rpat(step, l, 1);
            bus.res2_i[l] = rpat(step, l, 2);
        end
    end

    always @(posedge clk) begin
        if (bus.rd_en) begin
            for (int l = 0; l < PS; l++)
                for (int f = 0; f < 3; f++)
                    bus.rd_data[l][f] <= pat(int'(bus.rd_addr), l, f);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, "pipe_rst", bus.pipe_rst, 1);
        check(tag, "ctrl", {busy, done, ovf, cfg_err, bus.rd_en, bus.wr_en}, 0);
        check(tag, "addr", {bus.rd_addr, bus.wr_addr}, 0);
        check(tag, "streams", {|bus.operand_o, |bus.scale_o, |bus.pos_o, |bus.wr_data}, 0);
        check(tag, "stage_boundary", bus.stage_boundary, 0);
    endtask

    int   s_err_c, s_n_cerr, s_done_c, s_n_done, s_ovf, s_ovf_stray;
    int   s_n_rd, s_max_rd, s_rd_err, s_n_wr, s_wr_err, s_data_err, s_n_busy, s_n_run;
    bnd_t s_sb;

    task automatic run_case(input bnd_t bnd, input int inj_start, input bit chg_cfg, input int limit);
        bit run, exp_we;
        s_err_c = 0; s_n_cerr = 0; s_done_c = 0; s_n_done = 0; s_ovf = 0; s_ovf_stray = 0;
        s_n_rd = 0; s_max_rd = 0; s_rd_err = 0; s_n_wr = 0; s_wr_err = 0; s_data_err = 0;
        s_n_busy = 0; s_n_run = 0; s_sb = '0;
        @(negedge clk);
        cur_bnd      = bnd;
        boundary_cfg = bnd;
        start        = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = (c == inj_start);
            if (chg_cfg && c == 3) boundary_cfg = '0;
            if (cfg_err) begin s_n_cerr++; if (s_err_c == 0) s_err_c = c; end
            if (busy) s_n_busy++;
            if (done) begin
                s_n_done++;
                if (s_done_c == 0) begin s_done_c = c; s_ovf = ovf; s_sb = bus.stage_boundary; end
            end else if (ovf) s_ovf_stray++;
            if (bus.rd_en) begin
                s_n_rd++;
                if (int'(bus.rd_addr) > s_max_rd) s_max_rd = int'(bus.rd_addr);
                if (int'(bus.rd_addr) != c - 1) s_rd_err++;
            end
            run = !bus.pipe_rst;
            if (run) s_n_run++;
            exp_we = WB && run && MASK[stage_of(step, cur_bnd)];
            if (bus.wr_en !== exp_we) s_wr_err++;
            if (bus.wr_en === 1'b1) begin
                s_n_wr++;
                if (int'(bus.wr_addr) != step) s_wr_err++;
                for (int l = 0; l < PS; l++)
                    if (bus.wr_data[l][0] !== rpat(step, l, 1) || bus.wr_data[l][1] !== rpat(step, l, 2)) s_wr_err++;
            end else if (!WB && (bus.wr_addr !== '0 || bus.wr_data !== '0)) s_wr_err++;
            for (int l = 0; l < PS; l++) begin
                if (bus.operand_o[l] !== (run ? pat(step, l, 0) : 16'h0000) ||
                    bus.scale_o[l]   !== (run ? pat(step, l, 1) : 16'h0000) ||
                    bus.pos_o[l]     !== (run ? pat(step, l, 2) : 16'h0000)) s_data_err++;
            end
            if (s_done_c != 0 && c >= s_done_c + 2) break;
        end
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int exp_wr;
        int has_done;
        exp_wr   = WB ? v.exp_wr : 0;
        has_done = (v.exp_done != 0) ? 1 : 0;
        run_case(v.bnd, v.inj_start, v.chg_cfg, (v.exp_done == 0) ? 12 : v.exp_done + 3);
        check(tag, "cfg_err_cycle", s_err_c, v.exp_err_c);
        check(tag, "cfg_err_count", s_n_cerr, (v.exp_err_c != 0) ? 1 : 0);
        check(tag, "done_cycle", s_done_c, v.exp_done);
        check(tag, "done_count", s_n_done, has_done);
        check(tag, "ovf", s_ovf, v.exp_ovf);
        check(tag, "ovf_stray", s_ovf_stray, 0);
        check(tag, "busy_cycles", s_n_busy, has_done ? v.exp_done - 1 : 0);
        check(tag, "run_cycles", s_n_run, has_done ? v.exp_done - 2 : 0);
        check(tag, "rd_count", s_n_rd, v.exp_rd);
        check(tag, "rd_max_addr", s_max_rd, v.exp_max_rd);
        check(tag, "rd_addr_seq", s_rd_err, 0);
        check(tag, "wr_count", s_n_wr, exp_wr);
        check(tag, "wr_port", s_wr_err, 0);
        check(tag, "stream_data", s_data_err, 0);
        if (has_done != 0) check(tag, "stage_boundary", s_sb, v.bnd);
    endtask

    function automatic bnd_t mk(int b0, int b1, int b2, int b3, int b4, int b5, int b6);
        return {8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    vec_t vecs[8];

    initial begin
        //           bnd                              inj chg err done  wr ovf  rd max
        vecs[0] = '{mk(2,4,6,8,10,12,14),             0, 0,  0,  18,   6, 0,  16, 15};
        vecs[1] = '{mk(2,4,3,8,10,12,14),             0, 0,  1,   0,   0, 0,   0,  0};
        vecs[2] = '{mk(2,4,6,8,10,12,14),             5, 0,  0,  18,   6, 0,  16, 15};
        vecs[3] = '{mk(2,4,6,8,10,12,14),             0, 1,  0,  18,   6, 0,  16, 15};
        vecs[4] = '{mk(0,0,0,0,0,0,0),                0, 0,  0,   4,   0, 0,   2,  1};
        vecs[5] = '{mk(1,2,3,4,5,6,7),                0, 0,  0,  11,   3, 0,   9,  8};
        vecs[6] = '{mk(1,2,3,4,5,7,6),                0, 0,  1,   0,   0, 0,   0,  0};
        vecs[7] = '{mk(0,0,0,0,10,20,255),            0, 0,  0, 258, 255, 1, 256, 255};

        rst = 1'b1;
        start = 1'b0;
        boundary_cfg = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a run, at k = 6.
        @(negedge clk);
        cur_bnd      = mk(2,4,6,8,10,12,14);
        boundary_cfg = cur_bnd;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("midrst", "step_before_rst", step, 6);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        run_vec(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
